// File: rtl/pe_mac_row_if.sv
// pe_mac_row_if: stream and configuration bundle for one pe_mac_row.
//
// Handshake rule (all three streams): a beat transfers on a rising clock
// edge where the sender's rdy and the receiver's ack are both high. The PE
// drives ack (input/weight streams) and rdy (psum stream) purely from
// registered state, so the far side may sample them at any time in a cycle.
//
// Signals
//   i_cfg_valid/len/reps/signed : configuration strobe and fields (IDLE only)
//   i_in_rdy, o_in_ack, i_in_data : input element stream
//   i_wt_rdy, o_wt_ack, i_wt_data : weight vector stream (NCOL lanes)
//   o_ps_rdy, i_ps_ack, o_ps_data : partial-sum vector stream (NCOL lanes)
//   o_busy                        : high whenever the FSM is not IDLE
//   dbg_state                     : current FSM state encoding
// Modports: slave = the PE, master = the surrounding networks.
interface pe_mac_row_if #(
  parameter int DWD   = 8,
  parameter int PSWD  = 24,
  parameter int NCOL  = 4,
  parameter int IPADN = 12,
  parameter int RPW   = 4
);
  localparam int LW = $clog2(IPADN + 1);

  logic                 i_cfg_valid;
  logic [LW-1:0]        i_cfg_len;
  logic [RPW-1:0]       i_cfg_reps;
  logic                 i_cfg_signed;
  logic                 i_in_rdy;
  logic                 o_in_ack;
  logic [DWD-1:0]       i_in_data;
  logic                 i_wt_rdy;
  logic                 o_wt_ack;
  logic [NCOL*DWD-1:0]  i_wt_data;
  logic                 o_ps_rdy;
  logic                 i_ps_ack;
  logic [NCOL*PSWD-1:0] o_ps_data;
  logic                 o_busy;
  logic [2:0]           dbg_state;

  modport slave (
    input  i_cfg_valid, i_cfg_len, i_cfg_reps, i_cfg_signed,
    input  i_in_rdy, i_in_data, i_wt_rdy, i_wt_data, i_ps_ack,
    output o_in_ack, o_wt_ack, o_ps_rdy, o_ps_data, o_busy, dbg_state
  );

  modport master (
    output i_cfg_valid, i_cfg_len, i_cfg_reps, i_cfg_signed,
    output i_in_rdy, i_in_data, i_wt_rdy, i_wt_data, i_ps_ack,
    input  o_in_ack, o_wt_ack, o_ps_rdy, o_ps_data, o_busy, dbg_state
  );
endinterface

// File: rtl/pe_mac_row.sv
// pe_mac_row: input-stationary MAC processing element.
// Loads up to IPADN input elements into a local pad, then for each pass
// streams len weight vectors against the pad, multiplying pad[j] by every
// lane of weight beat j and accumulating into NCOL partial sums. After a
// two-cycle drain the sums are offered on the psum stream; further passes
// reuse the pad without reloading.
//
// Ports
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : pe_mac_row_if.slave (config, input, weight, psum streams,
//           o_busy, dbg_state)
//
// Build option: define PE_SAT_EN to saturate each accumulate instead of
// wrapping modulo 2^PSWD.
module pe_mac_row #(
  parameter int DWD   = 8,
  parameter int PSWD  = 24,
  parameter int NCOL  = 4,
  parameter int IPADN = 12,
  parameter int RPW   = 4
) (
  input logic         i_clk,
  input logic         i_rst,
  pe_mac_row_if.slave bus
);
  localparam int LW = $clog2(IPADN + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t           state;
  logic [LW-1:0]    len;
  logic [LW-1:0]    k;
  logic [RPW-1:0]   reps_left;
  logic             sgn;
  logic             drain_cnt;
  logic [DWD-1:0]   pad  [IPADN];
  logic [2*DWD-1:0] prod [NCOL];
  logic             prod_vld;
  logic [PSWD-1:0]  acc  [NCOL];
  logic             in_ack, wt_ack, ps_rdy, busy;
  logic             in_xfer, wt_xfer;
  logic [LW-1:0]    cfg_len_eff;

  assign in_xfer = in_ack & bus.i_in_rdy;
  assign wt_xfer = wt_ack & bus.i_wt_rdy;
  assign cfg_len_eff = (bus.i_cfg_len > LW'(IPADN)) ? LW'(IPADN) : bus.i_cfg_len;

  // Operands are extended to 2*DWD first; the low 2*DWD bits of that
  // product are the exact signed or unsigned product.
  function automatic logic [2*DWD-1:0] mul(input logic [DWD-1:0] a,
                                           input logic [DWD-1:0] b,
                                           input logic           s);
    logic [2*DWD-1:0] ea, eb;
    if (s) begin
      ea = (2*DWD)'($signed(a));
      eb = (2*DWD)'($signed(b));
    end else begin
      ea = (2*DWD)'(a);
      eb = (2*DWD)'(b);
    end
    mul = ea * eb;
  endfunction

  function automatic logic [PSWD-1:0] acc_add(input logic [PSWD-1:0]  a,
                                              input logic [2*DWD-1:0] p,
                                              input logic             s);
    logic [PSWD-1:0] pe;
`ifdef PE_SAT_EN
    logic [PSWD:0] sum;
`endif
    if (s) pe = PSWD'($signed(p));
    else   pe = PSWD'(p);
`ifdef PE_SAT_EN
    if (s) begin
      // One extra bit: overflow iff the two top bits disagree.
      sum = {a[PSWD-1], a} + {pe[PSWD-1], pe};
      if (sum[PSWD] != sum[PSWD-1])
        acc_add = sum[PSWD] ? {1'b1, {(PSWD-1){1'b0}}} : {1'b0, {(PSWD-1){1'b1}}};
      else
        acc_add = sum[PSWD-1:0];
    end else begin
      sum = {1'b0, a} + {1'b0, pe};
      acc_add = sum[PSWD] ? {PSWD{1'b1}} : sum[PSWD-1:0];
    end
`else
    acc_add = a + pe;
`endif
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      len       <= '0;
      k         <= '0;
      reps_left <= '0;
      sgn       <= 1'b0;
      drain_cnt <= 1'b0;
      prod_vld  <= 1'b0;
      in_ack    <= 1'b0;
      wt_ack    <= 1'b0;
      ps_rdy    <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < IPADN; i++) pad[i] <= '0;
      for (int c = 0; c < NCOL; c++) begin
        prod[c] <= '0;
        acc[c]  <= '0;
      end
    end else begin
      prod_vld <= 1'b0;
      // Second pipeline stage: the product registered last cycle lands in
      // the accumulator now. A pass clear below overrides this update.
      if (prod_vld) begin
        for (int c = 0; c < NCOL; c++) acc[c] <= acc_add(acc[c], prod[c], sgn);
      end
      case (state)
        S_IDLE: begin
          if (bus.i_cfg_valid && bus.i_cfg_len != '0) begin
            len       <= cfg_len_eff;
            reps_left <= (bus.i_cfg_reps == '0) ? '0 : bus.i_cfg_reps - RPW'(1);
            sgn       <= bus.i_cfg_signed;
            k         <= '0;
            in_ack    <= 1'b1;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_xfer) begin
            pad[k] <= bus.i_in_data;
            if (k == len - LW'(1)) begin
              k      <= '0;
              in_ack <= 1'b0;
              wt_ack <= 1'b1;
              for (int c = 0; c < NCOL; c++) acc[c] <= '0;
              state  <= S_COMPUTE;
            end else begin
              k <= k + LW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (wt_xfer) begin
            for (int c = 0; c < NCOL; c++)
              prod[c] <= mul(pad[k], bus.i_wt_data[c*DWD +: DWD], sgn);
            prod_vld <= 1'b1;
            if (k == len - LW'(1)) begin
              k         <= '0;
              wt_ack    <= 1'b0;
              drain_cnt <= 1'b0;
              state     <= S_DRAIN;
            end else begin
              k <= k + LW'(1);
            end
          end
        end
        S_DRAIN: begin
          // Two cycles: lets the final product reach the accumulators.
          if (drain_cnt) begin
            ps_rdy <= 1'b1;
            state  <= S_OUT;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.i_ps_ack) begin
            ps_rdy <= 1'b0;
            if (reps_left != '0) begin
              reps_left <= reps_left - RPW'(1);
              k         <= '0;
              wt_ack    <= 1'b1;
              for (int c = 0; c < NCOL; c++) acc[c] <= '0;
              state     <= S_COMPUTE;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NCOL; c++) begin : g_ps
    assign bus.o_ps_data[c*PSWD +: PSWD] = acc[c];
  end

  assign bus.o_in_ack  = in_ack;
  assign bus.o_wt_ack  = wt_ack;
  assign bus.o_ps_rdy  = ps_rdy;
  assign bus.o_busy    = busy;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_pe_mac_row.sv
module tb_pe_mac_row;
  localparam int DWD   = 8;
  localparam int PSWD  = 16;
  localparam int NCOL  = 4;
  localparam int IPADN = 12;
  localparam int RPW   = 4;
  localparam int LW    = $clog2(IPADN + 1);
  localparam int PW    = NCOL * PSWD;
`ifdef PE_SAT_EN
  localparam logic [PSWD-1:0] EXP_OVF = 16'd65535;
`else
  localparam logic [PSWD-1:0] EXP_OVF = 16'd64514;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_mac_row_if #(.DWD(DWD), .PSWD(PSWD), .NCOL(NCOL), .IPADN(IPADN), .RPW(RPW)) bus ();

  pe_mac_row #(.DWD(DWD), .PSWD(PSWD), .NCOL(NCOL), .IPADN(IPADN), .RPW(RPW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int in_xfers = 0;
  int wt_xfers = 0;

  logic [PW-1:0]       exp_q[$];
  logic [DWD-1:0]      in_vec [IPADN];
  logic [NCOL*DWD-1:0] wt_vec [IPADN];

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.i_in_rdy && bus.o_in_ack) in_xfers++;
      if (bus.i_wt_rdy && bus.o_wt_ack) wt_xfers++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] model_pass(input int len, input bit sgn);
    logic [PW-1:0]  r;
    longint         acc, a, b;
    logic [DWD-1:0] xa, xb;
    longint         maxu, maxs, mins;
    maxu = (longint'(1) << PSWD) - 1;
    maxs = (longint'(1) << (PSWD - 1)) - 1;
    mins = -(longint'(1) << (PSWD - 1));
    r = '0;
    for (int c = 0; c < NCOL; c++) begin
      acc = 0;
      for (int j = 0; j < len; j++) begin
        xa = in_vec[j];
        xb = wt_vec[j][c*DWD +: DWD];
        if (sgn) begin
          a = longint'($signed(xa));
          b = longint'($signed(xb));
        end else begin
          a = longint'(xa);
          b = longint'(xb);
        end
        acc = acc + a * b;
`ifdef PE_SAT_EN
        if (sgn) begin
          if (acc > maxs) acc = maxs;
          if (acc < mins) acc = mins;
        end else if (acc > maxu) begin
          acc = maxu;
        end
`endif
      end
      r[c*PSWD +: PSWD] = acc[PSWD-1:0];
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.i_cfg_valid = 1'b0; bus.i_cfg_len = '0; bus.i_cfg_reps = '0; bus.i_cfg_signed = 1'b0;
    bus.i_in_rdy = 1'b0; bus.i_in_data = '0;
    bus.i_wt_rdy = 1'b0; bus.i_wt_data = '0;
    bus.i_ps_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg(input int len, input int reps, input bit sgn);
    bus.i_cfg_valid  = 1'b1;
    bus.i_cfg_len    = LW'(len);
    bus.i_cfg_reps   = RPW'(reps);
    bus.i_cfg_signed = sgn;
    @(negedge clk);
    bus.i_cfg_valid = 1'b0;
  endtask

  task automatic send_input(input logic [DWD-1:0] d);
    int n = 0;
    bus.i_in_data = d;
    bus.i_in_rdy  = 1'b1;
    while (bus.o_in_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin chk_cnt++; $display("FAIL in_ack_timeout waited %0d cycles", n); end
    @(negedge clk);
    bus.i_in_rdy = 1'b0;
  endtask

  task automatic load_inputs(input int len);
    for (int j = 0; j < len; j++) send_input(in_vec[j]);
  endtask

  task automatic send_weight(input logic [NCOL*DWD-1:0] w, input bit gaps);
    int n = 0;
    if (gaps) begin
      bus.i_wt_rdy = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.i_wt_data = w;
    bus.i_wt_rdy  = 1'b1;
    while (bus.o_wt_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin chk_cnt++; $display("FAIL wt_ack_timeout waited %0d cycles", n); end
    @(negedge clk);
    bus.i_wt_rdy = 1'b0;
  endtask

  // Pushes the expected psum for this pass, then streams its weights.
  task automatic run_pass(input int len, input bit sgn, input bit gaps);
    exp_q.push_back(model_pass(len, sgn));
    for (int j = 0; j < len; j++) send_weight(wt_vec[j], gaps);
  endtask

  task automatic wait_ps(output bit ok);
    int n = 0;
    while (bus.o_ps_rdy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    ok = (bus.o_ps_rdy === 1'b1);
    if (!ok) begin chk_cnt++; $display("FAIL ps_rdy_timeout waited %0d cycles", n); end
  endtask

  task automatic ack_ps(output logic [PW-1:0] got);
    got = bus.o_ps_data;
    bus.i_ps_ack = 1'b1;
    @(negedge clk);
    bus.i_ps_ack = 1'b0;
  endtask

  task automatic rand_weights(input int len);
    for (int j = 0; j < len; j++)
      for (int c = 0; c < NCOL; c++) wt_vec[j][c*DWD +: DWD] = DWD'($urandom_range(1, 255));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    chk_cnt++; if (bus.o_in_ack !== 1'b0) $display("FAIL reset_in_ack got %b exp 0", bus.o_in_ack); else pass_cnt++;
    chk_cnt++; if (bus.o_wt_ack !== 1'b0) $display("FAIL reset_wt_ack got %b exp 0", bus.o_wt_ack); else pass_cnt++;
    chk_cnt++; if (bus.o_ps_rdy !== 1'b0) $display("FAIL reset_ps_rdy got %b exp 0", bus.o_ps_rdy); else pass_cnt++;
    chk_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.o_busy); else pass_cnt++;
    chk_cnt++; if (bus.o_ps_data !== '0) $display("FAIL reset_ps_data got %h exp 0", bus.o_ps_data); else pass_cnt++;
    chk_cnt++; if (bus.dbg_state !== 3'd0) $display("FAIL reset_state got %0d exp 0", bus.dbg_state); else pass_cnt++;
  endtask

  task automatic test_unsigned_basic();
    logic [PW-1:0] got, exp;
    bit ok;
    int n;
    for (int j = 0; j < 3; j++) begin
      in_vec[j] = DWD'(j + 1);
      wt_vec[j] = {NCOL{DWD'(4 + j)}};
    end
    cfg(3, 1, 0);
    chk_cnt++; if (bus.o_in_ack !== 1'b1) $display("FAIL basic_cfg_to_in_ack got %b exp 1", bus.o_in_ack); else pass_cnt++;
    load_inputs(3);
    run_pass(3, 0, 0);
    n = 0;
    while (bus.o_ps_rdy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk_cnt++; if (n != 2) $display("FAIL basic_ps_latency got %0d exp 2 cycles after DRAIN entry", n); else pass_cnt++;
    wait_ps(ok);
    ack_ps(got);
    exp = exp_q.pop_front();
    chk_cnt++; if (!ok || got !== exp) $display("FAIL basic_psum got %h exp %h", got, exp); else pass_cnt++;
    chk_cnt++; if (got !== {NCOL{PSWD'(32)}}) $display("FAIL basic_psum_32 got %h exp all 32", got); else pass_cnt++;
    chk_cnt++; if (bus.o_ps_rdy !== 1'b0 || bus.o_busy !== 1'b0)
      $display("FAIL basic_after_ack got rdy %b busy %b exp 0 0", bus.o_ps_rdy, bus.o_busy); else pass_cnt++;
  endtask

  task automatic test_signed_reuse();
    logic [PW-1:0] got, exp;
    bit ok;
    int in_snap;
    in_vec[0] = 8'hFD;
    in_vec[1] = 8'd7;
    rand_weights(2);
    wt_vec[0][DWD-1:0] = 8'd2;
    wt_vec[1][DWD-1:0] = 8'd1;
    cfg(2, 2, 1);
    load_inputs(2);
    run_pass(2, 1, 0);
    wait_ps(ok);
    ack_ps(got);
    exp = exp_q.pop_front();
    chk_cnt++; if (!ok || got !== exp) $display("FAIL signed_pass1 got %h exp %h", got, exp); else pass_cnt++;
    chk_cnt++; if (got[PSWD-1:0] !== 16'd1) $display("FAIL signed_pass1_ch0 got %h exp 0001", got[PSWD-1:0]); else pass_cnt++;
    chk_cnt++; if (bus.o_ps_rdy !== 1'b0 || bus.o_wt_ack !== 1'b1)
      $display("FAIL signed_next_pass got rdy %b wt_ack %b exp 0 1", bus.o_ps_rdy, bus.o_wt_ack); else pass_cnt++;
    in_snap = in_xfers;
    wt_vec[0][DWD-1:0] = 8'hFF;
    wt_vec[1][DWD-1:0] = 8'hFF;
    bus.i_in_rdy = 1'b1;
    run_pass(2, 1, 0);
    wait_ps(ok);
    ack_ps(got);
    bus.i_in_rdy = 1'b0;
    exp = exp_q.pop_front();
    chk_cnt++; if (!ok || got !== exp) $display("FAIL signed_pass2 got %h exp %h", got, exp); else pass_cnt++;
    chk_cnt++; if (got[PSWD-1:0] !== 16'hFFFC) $display("FAIL signed_pass2_ch0 got %h exp fffc", got[PSWD-1:0]); else pass_cnt++;
    chk_cnt++; if (in_xfers != in_snap) $display("FAIL signed_no_reload got %0d input acks exp 0", in_xfers - in_snap); else pass_cnt++;
    chk_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL signed_done_busy got %b exp 0", bus.o_busy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] got, exp, d0;
    bit ok, stable;
    int wt_snap, in_snap;
    for (int j = 0; j < 3; j++) in_vec[j] = DWD'($urandom_range(0, 255));
    rand_weights(3);
    cfg(3, 2, 0);
    load_inputs(3);
    run_pass(3, 0, 0);
    wait_ps(ok);
    d0 = bus.o_ps_data;
    wt_snap = wt_xfers;
    in_snap = in_xfers;
    stable = 1'b1;
    bus.i_wt_rdy = 1'b1;
    bus.i_in_rdy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_ps_data !== d0 || bus.o_ps_rdy !== 1'b1) stable = 1'b0;
    end
    bus.i_wt_rdy = 1'b0;
    bus.i_in_rdy = 1'b0;
    chk_cnt++; if (!stable) $display("FAIL bp_hold_stable got %h exp %h held", bus.o_ps_data, d0); else pass_cnt++;
    chk_cnt++; if (wt_xfers != wt_snap || in_xfers != in_snap)
      $display("FAIL bp_no_acks got %0d wt %0d in acks exp 0 0", wt_xfers - wt_snap, in_xfers - in_snap); else pass_cnt++;
    ack_ps(got);
    exp = exp_q.pop_front();
    chk_cnt++; if (!ok || got !== exp) $display("FAIL bp_psum got %h exp %h", got, exp); else pass_cnt++;
    run_pass(3, 0, 1);
    wait_ps(ok);
    ack_ps(got);
    exp = exp_q.pop_front();
    chk_cnt++; if (!ok || got !== exp) $display("FAIL gap_psum got %h exp %h", got, exp); else pass_cnt++;
  endtask

  task automatic test_len_zero();
    cfg(0, 1, 0);
    @(negedge clk);
    chk_cnt++; if (bus.o_busy !== 1'b0 || bus.dbg_state !== 3'd0 || bus.o_in_ack !== 1'b0)
      $display("FAIL len0_idle got busy %b state %0d in_ack %b exp 0 0 0", bus.o_busy, bus.dbg_state, bus.o_in_ack);
    else pass_cnt++;
  endtask

  task automatic test_len_clamp();
    logic [PW-1:0] got, exp;
    bit ok;
    int in_snap;
    for (int j = 0; j < IPADN; j++) in_vec[j] = DWD'($urandom_range(0, 255));
    rand_weights(IPADN);
    in_snap = in_xfers;
    cfg(15, 1, 0);
    load_inputs(IPADN);
    bus.i_in_rdy = 1'b1;
    repeat (4) @(negedge clk);
    bus.i_in_rdy = 1'b0;
    chk_cnt++; if (in_xfers - in_snap != IPADN) $display("FAIL clamp_in_acks got %0d exp %0d", in_xfers - in_snap, IPADN); else pass_cnt++;
    chk_cnt++; if (bus.dbg_state !== 3'd2) $display("FAIL clamp_state got %0d exp 2", bus.dbg_state); else pass_cnt++;
    run_pass(IPADN, 0, 0);
    wait_ps(ok);
    ack_ps(got);
    exp = exp_q.pop_front();
    chk_cnt++; if (!ok || got !== exp) $display("FAIL clamp_psum got %h exp %h", got, exp); else pass_cnt++;
  endtask

  task automatic test_reps_zero();
    logic [PW-1:0] got, exp;
    bit ok, extra;
    for (int j = 0; j < 2; j++) in_vec[j] = DWD'($urandom_range(0, 255));
    rand_weights(2);
    cfg(2, 0, 1);
    load_inputs(2);
    run_pass(2, 1, 0);
    wait_ps(ok);
    ack_ps(got);
    exp = exp_q.pop_front();
    chk_cnt++; if (!ok || got !== exp) $display("FAIL reps0_psum got %h exp %h", got, exp); else pass_cnt++;
    extra = 1'b0;
    bus.i_wt_rdy = 1'b1;
    repeat (6) begin
      if (bus.o_ps_rdy !== 1'b0 || bus.o_busy !== 1'b0) extra = 1'b1;
      @(negedge clk);
    end
    bus.i_wt_rdy = 1'b0;
    chk_cnt++; if (extra) $display("FAIL reps0_single_psum got extra pass activity exp idle"); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [PW-1:0] got, exp;
    bit ok;
    in_vec[0] = 8'd255;
    in_vec[1] = 8'd255;
    wt_vec[0] = {NCOL{8'd255}};
    wt_vec[1] = {NCOL{8'd255}};
    cfg(2, 1, 0);
    load_inputs(2);
    run_pass(2, 0, 0);
    wait_ps(ok);
    ack_ps(got);
    exp = exp_q.pop_front();
    chk_cnt++; if (!ok || got !== exp) $display("FAIL ovf_psum got %h exp %h", got, exp); else pass_cnt++;
    chk_cnt++; if (got[PSWD-1:0] !== EXP_OVF) $display("FAIL ovf_ch0 got %0d exp %0d", got[PSWD-1:0], EXP_OVF); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [PW-1:0] got, exp;
    bit ok;
    for (int j = 0; j < 3; j++) in_vec[j] = DWD'($urandom_range(1, 255));
    rand_weights(3);
    cfg(3, 1, 0);
    load_inputs(3);
    send_weight(wt_vec[0], 0);
    send_weight(wt_vec[1], 0);
    chk_cnt++; if (bus.o_ps_data === '0) $display("FAIL mid_acc_live got %h exp nonzero", bus.o_ps_data); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.o_in_ack !== 1'b0 || bus.o_wt_ack !== 1'b0 || bus.o_ps_rdy !== 1'b0 || bus.o_busy !== 1'b0)
      $display("FAIL mid_reset_ctrl got in %b wt %b ps %b busy %b exp 0 0 0 0",
               bus.o_in_ack, bus.o_wt_ack, bus.o_ps_rdy, bus.o_busy);
    else pass_cnt++;
    chk_cnt++; if (bus.o_ps_data !== '0 || bus.dbg_state !== 3'd0)
      $display("FAIL mid_reset_data got data %h state %0d exp 0 0", bus.o_ps_data, bus.dbg_state); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 2; j++) in_vec[j] = DWD'($urandom_range(0, 255));
    rand_weights(2);
    cfg(2, 1, 0);
    load_inputs(2);
    run_pass(2, 0, 0);
    wait_ps(ok);
    ack_ps(got);
    exp = exp_q.pop_front();
    chk_cnt++; if (!ok || got !== exp) $display("FAIL mid_reset_fresh got %h exp %h", got, exp); else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_reuse();
    test_backpressure();
    test_len_zero();
    test_len_clamp();
    test_reps_zero();
    test_overflow();
    test_mid_reset();
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL sb_drained got %0d left exp 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/pe_mac_row.md
# pe_mac_row

Parametrised input-stationary processing element: buffers a configurable-length input vector in a local pad, then streams weight vectors against it through a pipelined multiply-accumulate datapath feeding NCOL parallel partial-sum channels. Supports repeated passes over the same stored inputs and signed or unsigned arithmetic. It sits in the PE array between the input and weight distribution networks and the psum collection network, with rdy/ack handshakes on all three streams.

## Interface
- DWD, 8, input and weight data width
- PSWD, 24, psum/accumulator width (must be ≥ 2*DWD)
- NCOL, 4, output channels (weights per weight beat)
- IPADN, 12, input pad depth (maximum pass length)
- RPW, 4, width of repeat-count field
- LW = $clog2(IPADN+1), derived, length-field width

- i_clk  in  1  clock, all logic rising-edge
- i_rst  in  1  synchronous, active-high reset
- i_cfg_valid  in  1  config strobe, sampled only in IDLE
- i_cfg_len  in  LW  inputs per pass
- i_cfg_reps  in  RPW  passes over the stored inputs
- i_cfg_signed  in  1  1 = two's-complement operands
- i_in_rdy / o_in_ack  in / out  1 / 1  input stream handshake
- i_in_data  in  DWD  input element
- i_wt_rdy / o_wt_ack  in / out  1 / 1  weight stream handshake
- i_wt_data  in  NCOL*DWD  weight vector, channel c at bits [c*DWD +: DWD]
- o_ps_rdy / i_ps_ack  out / in  1 / 1  psum stream handshake
- o_ps_data  out  NCOL*PSWD  psum vector, channel c at bits [c*PSWD +: PSWD]
- o_busy  out  1  high whenever state ≠ IDLE

## Operation
- Transfer on any stream: rdy && ack in the same cycle.
- FSM states: IDLE, LOAD, COMPUTE, DRAIN, OUT.
- IDLE: on i_cfg_valid, latch len, reps, and signed, then go to LOAD.
  - len = 0: config ignored; stay in IDLE.
  - len > IPADN: clamped to IPADN.
  - reps = 0: treated as 1.
- LOAD: o_in_ack = 1. Each input transfer writes pad[k] and increments k. After the len-th transfer, go to COMPUTE with k = 0.
- COMPUTE: o_wt_ack = 1.
  - At the start of each pass, all accumulators are cleared.
  - Weight transfer j pairs pad[j] with each weight channel and issues NCOL products into the pipeline.
  - After the len-th weight transfer, go to DRAIN.
- DRAIN: 2 cycles, with no acks asserted. Then go to OUT.
- OUT: o_ps_rdy = 1 and o_ps_data = accumulators. On i_ps_ack:
  - if passes remain, decrement the remaining count and return to COMPUTE; pad contents are reused and not reloaded;
  - otherwise return to IDLE.
- Arithmetic:
  - products are 2*DWD wide;
  - signed mode sign-extends operands and products, unsigned mode zero-extends;
  - products are extended to PSWD and added to the accumulator;
  - default overflow behaviour is wrap modulo 2^PSWD.
- Rdy signals raised by upstream senders outside the accepting state are not acked and cause no state change.

## Timing
- Reset values: o_in_ack, o_wt_ack, o_ps_rdy, o_busy = 0; o_ps_data = 0; state = IDLE; accumulators, counters, and pad = 0.
- Reset asserted mid-operation aborts everything. Outputs reach reset values in the cycle after the reset edge.
- Config seen in cycle t: o_in_ack is high from t+1.
- Acks are registered state decodes. In COMPUTE, full throughput of one weight beat per cycle is required.
- Pipeline: weight accepted in cycle t → product register updated at end of t → accumulator updated at end of t+1.
- Last weight transfer in cycle t:
  - DRAIN occupies t+1 and t+2;
  - o_ps_rdy is high from t+3;
  - minimum config-to-first-psum latency is len + len + 3 cycles.
- While o_ps_rdy && !i_ps_ack, o_ps_data is held stable.
- o_ps_rdy drops in the cycle after ack:
  - if passes remain, o_wt_ack is high in that same cycle;
  - otherwise o_busy drops in that cycle.
- i_cfg_valid outside IDLE is ignored.

## Configuration
- PE_SAT_EN defined:
  - accumulation saturates instead of wrapping;
  - signed mode clamps to [-2^(PSWD-1), 2^(PSWD-1)-1];
  - unsigned mode clamps to 2^PSWD-1;
  - once saturated, an accumulator holds until the next pass clear unless a later opposite-sign product brings it back in range (saturation is applied per add).
- PE_SAT_EN undefined: modulo-2^PSWD wrap, with no saturation logic.

## Test plan
- Unsigned basic (defaults): len=3, reps=1, inputs 1,2,3, weight beats all-channels 4,5,6 → one psum with every channel = 32; o_ps_rdy rises exactly 3 cycles after the last weight ack.
- Signed reuse: len=2, reps=2, inputs -3,7, signed=1.
  - Pass 1 channel0 weights 2,1 → channel0 = 1.
  - Pass 2 weights -1,-1 → channel0 = -4.
  - No input acks occur during pass 2.
- Backpressure:
  - hold i_ps_ack=0 for 5 cycles → o_ps_data is stable and no weight acks occur;
  - gaps in i_wt_rdy → same result as gapless.
- Boundaries:
  - len=0 → stays IDLE, o_busy=0;
  - len=15 with IPADN=12 → exactly 12 input acks;
  - reps=0 → exactly one psum.
- Overflow (PSWD=16, unsigned, len=2, inputs 255,255, weights 255,255; 2*65025 = 130050 exceeds 65535):
  - without PE_SAT_EN → 64514 (130050 mod 65536);
  - with PE_SAT_EN → 65535.
- Mid-pass reset: assert i_rst during COMPUTE → next cycle all outputs are 0 and state is IDLE; a fresh config then produces correct results unaffected by stale accumulators.
